mux32x64_tree: RTL and testbench
================================

Name: mux32x64_tree

Overview:
- 32-input, WIDTH-bit one-hot-free select multiplexer, used as the register-file read-port selector in the CPU datapath.
- Built structurally as a tree of two leaf primitives, mux4_1 and mux2_1. Both are defined as part of this block.
- Provides a combinational output `out`.
- Also provides a registered copy `out_q`, cleared by an asynchronous active-low reset, for pipelined read paths.

Parameters:
- WIDTH, 64, bit width of every data input and both outputs (all leaf muxes inherit it).

Ports:
- clk  input  1  single clock; rising edge updates out_q
- rst_n  input  1  asynchronous active-low reset; clears out_q
- in00000 … in11111  input  WIDTH each (32 ports)  data inputs; port suffix is the 5-bit binary select code that routes it
- sel  input  5  select code, sel[4] MSB
- out  output  WIDTH  combinational selected data
- out_q  output  WIDTH  registered selected data

Behaviour:
- mux2_1 leaf: ports out, i0, i1, sel (all WIDTH except sel=1 bit).
  - out = sel ? i1 : i0.
  - Purely combinational, bitwise.
- mux4_1 leaf: ports out, i00, i01, i10, i11, sel0, sel1.
  - sel1 is the MSB.
  - {sel1,sel0}=00→i00, 01→i01, 10→i10, 11→i11.
  - Built from three mux2_1 instances.
  - Purely combinational.
- Tree level 1: eight mux4_1 instances, all driven by sel0=sel[0] and sel1=sel[1].
  - Instance k takes inputs with codes 4k..4k+3 and produces vk (k=0..7).
- Tree level 2: two mux4_1 instances with sel0=sel[2] and sel1=sel[3].
  - v8 from v0..v3.
  - v9 from v4..v7.
- Tree level 3: one mux2_1 with sel=sel[4] selects v8 (0) or v9 (1) onto out.
- Net function: out = in<sel> for every sel value 0..31; no invalid codes.
- out is combinational, zero-cycle latency. Any input or sel change propagates with no clock involvement.
- out_q:
  - On each rising clk edge with rst_n=1, out_q ← out (1-cycle latency).
  - When rst_n=0, out_q = 0 immediately, regardless of clk, and stays 0 while reset is held.
  - Reset has no effect on out.
- Reset release: the first rising clk edge after rst_n returns high loads out_q with the current out.
- Simultaneous sel and data change before an edge: out_q captures the settled value at that edge.
- X/Z on sel: out may be X. No X-resolution logic is required.
- No handshake, enable or state machine.

Test Plan:
- Preset inputs: in00000=17, in01100=2, in01101=25, in10001=151, all other inputs=15. Apply sel=3 → out=15. After the next clk edge, out_q=15.
- sel=0 → out=17 immediately. sel=13 → out=25. sel=12 → out=2. sel=17 → out=151 (exercises the sel[4] branch and the m4 leaf).
- Exhaustive sweep: in<i>=i+64'h1000 for i=0..31, sel swept 0..31 → out equals 1000h+sel at every step. out_q equals the previous cycle's out.
- Bit-independence check: set in11111=64'hFFFF_FFFF_FFFF_FFFF and in11110=0. Toggle sel between 31 and 30 → all 64 out bits flip together.
- Reset: with out_q=25, assert rst_n=0 between clk edges → out_q=0 at once while out stays 25. Deassert → out_q=25 after the next rising edge.
- Leaf units: mux4_1 with i00..i11=1,2,3,4 and {sel1,sel0}=00..11 → 1,2,3,4. mux2_1 with i0=5, i1=9 and sel 0/1 → 5/9.

Source files
------------

// File: rtl/mux32x64_tree.sv
// 32:1 WIDTH-bit select mux tree for the register-file read port.
// Combinational out plus a registered out_q for pipelined reads.

module mux2_1 #(
  parameter int WIDTH = 64
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel
);
  assign out = sel ? i1 : i0;
endmodule

module mux4_1 #(
  parameter int WIDTH = 64
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] i00,
  input  logic [WIDTH-1:0] i01,
  input  logic [WIDTH-1:0] i10,
  input  logic [WIDTH-1:0] i11,
  input  logic             sel0,
  input  logic             sel1
);
  logic [WIDTH-1:0] lo, hi;

  mux2_1 #(.WIDTH(WIDTH)) u_lo (
    .out(lo), .i0(i00), .i1(i01), .sel(sel0)
  );
  mux2_1 #(.WIDTH(WIDTH)) u_hi (
    .out(hi), .i0(i10), .i1(i11), .sel(sel0)
  );
  mux2_1 #(.WIDTH(WIDTH)) u_top (
    .out(out), .i0(lo), .i1(hi), .sel(sel1)
  );
endmodule

module mux32x64_tree #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in00000,
  input  logic [WIDTH-1:0] in00001,
  input  logic [WIDTH-1:0] in00010,
  input  logic [WIDTH-1:0] in00011,
  input  logic [WIDTH-1:0] in00100,
  input  logic [WIDTH-1:0] in00101,
  input  logic [WIDTH-1:0] in00110,
  input  logic [WIDTH-1:0] in00111,
  input  logic [WIDTH-1:0] in01000,
  input  logic [WIDTH-1:0] in01001,
  input  logic [WIDTH-1:0] in01010,
  input  logic [WIDTH-1:0] in01011,
  input  logic [WIDTH-1:0] in01100,
  input  logic [WIDTH-1:0] in01101,
  input  logic [WIDTH-1:0] in01110,
  input  logic [WIDTH-1:0] in01111,
  input  logic [WIDTH-1:0] in10000,
  input  logic [WIDTH-1:0] in10001,
  input  logic [WIDTH-1:0] in10010,
  input  logic [WIDTH-1:0] in10011,
  input  logic [WIDTH-1:0] in10100,
  input  logic [WIDTH-1:0] in10101,
  input  logic [WIDTH-1:0] in10110,
  input  logic [WIDTH-1:0] in10111,
  input  logic [WIDTH-1:0] in11000,
  input  logic [WIDTH-1:0] in11001,
  input  logic [WIDTH-1:0] in11010,
  input  logic [WIDTH-1:0] in11011,
  input  logic [WIDTH-1:0] in11100,
  input  logic [WIDTH-1:0] in11101,
  input  logic [WIDTH-1:0] in11110,
  input  logic [WIDTH-1:0] in11111,
  input  logic [4:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
);
  logic [WIDTH-1:0] in_a [32];
  logic [WIDTH-1:0] v    [10];
  logic [WIDTH-1:0] out_d;

  assign in_a[0]  = in00000;
  assign in_a[1]  = in00001;
  assign in_a[2]  = in00010;
  assign in_a[3]  = in00011;
  assign in_a[4]  = in00100;
  assign in_a[5]  = in00101;
  assign in_a[6]  = in00110;
  assign in_a[7]  = in00111;
  assign in_a[8]  = in01000;
  assign in_a[9]  = in01001;
  assign in_a[10] = in01010;
  assign in_a[11] = in01011;
  assign in_a[12] = in01100;
  assign in_a[13] = in01101;
  assign in_a[14] = in01110;
  assign in_a[15] = in01111;
  assign in_a[16] = in10000;
  assign in_a[17] = in10001;
  assign in_a[18] = in10010;
  assign in_a[19] = in10011;
  assign in_a[20] = in10100;
  assign in_a[21] = in10101;
  assign in_a[22] = in10110;
  assign in_a[23] = in10111;
  assign in_a[24] = in11000;
  assign in_a[25] = in11001;
  assign in_a[26] = in11010;
  assign in_a[27] = in11011;
  assign in_a[28] = in11100;
  assign in_a[29] = in11101;
  assign in_a[30] = in11110;
  assign in_a[31] = in11111;

  // Leaf k covers select codes 4k..4k+3
  for (genvar k = 0; k < 8; k++) begin : g_l1
    mux4_1 #(.WIDTH(WIDTH)) u_m4 (
      .out (v[k]),
      .i00 (in_a[4*k]),
      .i01 (in_a[4*k+1]),
      .i10 (in_a[4*k+2]),
      .i11 (in_a[4*k+3]),
      .sel0(sel[0]),
      .sel1(sel[1])
    );
  end

  mux4_1 #(.WIDTH(WIDTH)) u_l2_lo (
    .out (v[8]),
    .i00 (v[0]), .i01(v[1]),
    .i10 (v[2]), .i11(v[3]),
    .sel0(sel[2]), .sel1(sel[3])
  );

  mux4_1 #(.WIDTH(WIDTH)) u_l2_hi (
    .out (v[9]),
    .i00 (v[4]), .i01(v[5]),
    .i10 (v[6]), .i11(v[7]),
    .sel0(sel[2]), .sel1(sel[3])
  );

  mux2_1 #(.WIDTH(WIDTH)) u_l3 (
    .out(out), .i0(v[8]), .i1(v[9]), .sel(sel[4])
  );

  always_comb begin
    out_d = out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end
endmodule

// File: tb/tb_mux32x64_tree.sv
// Scoreboard bench for mux32x64_tree and its mux4_1/mux2_1 leaves.
// Directed vectors push expectations; a monitor pops and compares.

module tb_mux32x64_tree;
  localparam int W = 64;

  typedef struct {
    string       name;
    logic [63:0] exp;
    int          kind;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din [32];
  logic [4:0]   sel = '0;
  logic [W-1:0] out, out_q;

  logic [W-1:0] a00, a01, a10, a11, m4_out;
  logic         s0, s1;
  logic [W-1:0] b0, b1, m2_out;
  logic         bs;

  exp_t sb [$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mux32x64_tree #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in00000(din[0]),  .in00001(din[1]),
    .in00010(din[2]),  .in00011(din[3]),
    .in00100(din[4]),  .in00101(din[5]),
    .in00110(din[6]),  .in00111(din[7]),
    .in01000(din[8]),  .in01001(din[9]),
    .in01010(din[10]), .in01011(din[11]),
    .in01100(din[12]), .in01101(din[13]),
    .in01110(din[14]), .in01111(din[15]),
    .in10000(din[16]), .in10001(din[17]),
    .in10010(din[18]), .in10011(din[19]),
    .in10100(din[20]), .in10101(din[21]),
    .in10110(din[22]), .in10111(din[23]),
    .in11000(din[24]), .in11001(din[25]),
    .in11010(din[26]), .in11011(din[27]),
    .in11100(din[28]), .in11101(din[29]),
    .in11110(din[30]), .in11111(din[31]),
    .sel(sel), .out(out), .out_q(out_q)
  );

  mux4_1 #(.WIDTH(W)) u_m4 (
    .out(m4_out), .i00(a00), .i01(a01),
    .i10(a10), .i11(a11), .sel0(s0), .sel1(s1)
  );

  mux2_1 #(.WIDTH(W)) u_m2 (
    .out(m2_out), .i0(b0), .i1(b1), .sel(bs)
  );

  // kind: 0=out 1=out_q 2=mux4_1 3=mux2_1
  task automatic expect_v(input string nm,
                          input logic [63:0] e,
                          input int k);
    exp_t x;
    x.name = nm;
    x.exp  = e;
    x.kind = k;
    sb.push_back(x);
    #1;
  endtask

  initial begin : monitor
    exp_t        x;
    logic [63:0] act;
    forever begin
      wait (sb.size() != 0);
      x = sb.pop_front();
      case (x.kind)
        0:       act = out;
        1:       act = out_q;
        2:       act = m4_out;
        default: act = m2_out;
      endcase
      n_chk++;
      if (act !== x.exp) begin
        n_fail++;
        $display("FAIL %s: got %h want %h",
                 x.name, act, x.exp);
      end
    end
  end

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic after_pos();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [63:0] ones;
    ones = '1;
    a00 = 1; a01 = 2; a10 = 3; a11 = 4;
    s0 = 0; s1 = 0;
    b0 = 5; b1 = 9; bs = 0;
    for (int i = 0; i < 32; i++) din[i] = 64'd15;
    din[0]  = 64'd17;
    din[12] = 64'd2;
    din[13] = 64'd25;
    din[17] = 64'd151;
    sel = 5'd3;

    #2;
    expect_v("reset_out_q", 64'd0, 1);
    expect_v("sel3_out", 64'd15, 0);
    after_pos();
    expect_v("reset_hold_q", 64'd0, 1);
    at_neg();
    rst_n = 1'b1;
    after_pos();
    expect_v("sel3_out_q", 64'd15, 1);

    at_neg();
    sel = 5'd0;  #1; expect_v("sel0_out", 64'd17, 0);
    sel = 5'd13; #1; expect_v("sel13_out", 64'd25, 0);
    sel = 5'd12; #1; expect_v("sel12_out", 64'd2, 0);
    sel = 5'd17; #1; expect_v("sel17_out", 64'd151, 0);

    // Async reset between edges with out_q holding 25
    at_neg();
    sel = 5'd13;
    after_pos();
    expect_v("pre_rst_q", 64'd25, 1);
    at_neg();
    rst_n = 1'b0;
    #1;
    expect_v("async_rst_q", 64'd0, 1);
    expect_v("rst_out_kept", 64'd25, 0);
    after_pos();
    expect_v("rst_held_q", 64'd0, 1);
    at_neg();
    rst_n = 1'b1;
    #1;
    expect_v("rel_no_edge_q", 64'd0, 1);
    after_pos();
    expect_v("rel_edge_q", 64'd25, 1);

    for (int i = 0; i < 32; i++) din[i] = 64'h1000 + 64'(i);
    for (int s = 0; s < 32; s++) begin
      at_neg();
      sel = 5'(s);
      #1;
      expect_v($sformatf("sweep_out_%0d", s),
               64'h1000 + 64'(s), 0);
      after_pos();
      expect_v($sformatf("sweep_q_%0d", s),
               64'h1000 + 64'(s), 1);
    end

    // Sel and data change together before one edge
    at_neg();
    sel = 5'd5;
    din[5] = 64'hABCD;
    after_pos();
    expect_v("simul_q", 64'hABCD, 1);

    din[31] = ones;
    din[30] = 64'd0;
    at_neg();
    sel = 5'd31; #1; expect_v("bits_31", ones, 0);
    sel = 5'd30; #1; expect_v("bits_30", 64'd0, 0);
    sel = 5'd31; #1; expect_v("bits_31b", ones, 0);

    {s1, s0} = 2'b00; #1; expect_v("m4_00", 64'd1, 2);
    {s1, s0} = 2'b01; #1; expect_v("m4_01", 64'd2, 2);
    {s1, s0} = 2'b10; #1; expect_v("m4_10", 64'd3, 2);
    {s1, s0} = 2'b11; #1; expect_v("m4_11", 64'd4, 2);
    bs = 1'b0; #1; expect_v("m2_0", 64'd5, 3);
    bs = 1'b1; #1; expect_v("m2_1", 64'd9, 3);

    for (int t = 0; t < 100 && sb.size() != 0; t++) #1;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending want 0",
               sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end
endmodule
